vga_sync_monitor: RTL and testbench
===================================

// Module: vga_sync_monitor
// PURPOSE
//  Receive-side counterpart of the VGA sync generator: watches o_VGA_HSync/o_VGA_VSync looped back on-chip,
//  recovers the raster position and measures line/frame timing. Declares lock after LOCK_FRAMES clean frames
//  and flags any timing deviation. Used as a built-in self-check of the video path and as raster source for bench checkers.
// PARAMETERS
//  H_LINE       800  expected clocks per line (92+50+640+18)
//  V_FRAME      525  expected lines per frame (2+33+480+10)
//  H_SYNC       92   expected HSync low width, clocks
//  V_SYNC       2    expected VSync low width, lines
//  LOCK_FRAMES  2    consecutive clean frames needed to lock (1..7)
// PORTS
//  i_Clk          in   1   pixel clock (25 MHz)
//  i_Reset        in   1   asynchronous, active-high reset
//  i_VGA_HSync    in   1   horizontal sync, active low, synchronous to i_Clk
//  i_VGA_VSync    in   1   vertical sync, active low, synchronous to i_Clk
//  o_h_count      out  10  recovered clock index within line, 0 = first HSync-low clock
//  o_v_count      out  10  recovered line index within frame, 0 = first VSync-low line
//  o_line_len     out  10  last measured line length, clocks
//  o_frame_lines  out  10  last measured frame length, lines
//  o_frame_start  out  1   one-cycle pulse on each detected VSync falling edge
//  o_locked       out  1   timing matches parameters
//  o_error        out  1   one-cycle pulse on a timing mismatch while CHECK or LOCKED
// BEHAVIOUR
//  Reset: all outputs 0; FSM = SEARCH; input history registers = 1 (idle high); internal counters 0.
//  Inputs registered once (r_hs, r_vs); edges taken from r_x vs its previous value: 1 cycle input latency.
//  hs_fall (r_hs_d=1, r_hs=0): o_h_count<=0, o_line_len<=o_h_count+1. Otherwise o_h_count+1, saturating at 1023.
//  HSync width: counter clears on hs_fall, counts while r_hs=0, compared with H_SYNC on HSync rising edge.
//  vs_fall on same cycle as hs_fall (normal case): o_v_count<=0, o_frame_lines<=o_v_count+1, o_frame_start=1.
//  vs_fall without hs_fall: frame-start pending flag set; applied at next hs_fall (o_frame_start on vs_fall cycle).
//  hs_fall without frame start: o_v_count+1, saturating at 1023.
//  VSync width measured in hs_fall events while r_vs=0; compared with V_SYNC on VSync rising edge.
//  Saturation of either count is a mismatch. Measured-value registers update in every FSM state.
//  FSM (2-bit state, 3-bit good-frame counter):
//   SEARCH: ignore mismatches; on vs_fall -> CHECK, good=0, frame-dirty=0.
//   CHECK : mismatch (line_len!=H_LINE at hs_fall, excluding first hs_fall after entry; HSync/VSync width
//           wrong; saturation) -> o_error, SEARCH. On vs_fall: frame_lines==V_FRAME and not dirty -> good+1;
//           good reaching LOCK_FRAMES -> LOCKED, o_locked<=1 next cycle.
//   LOCKED: any mismatch or frame_lines!=V_FRAME at vs_fall -> o_error, o_locked<=0, SEARCH (same cycle).
//  Simultaneous mismatch and vs_fall: mismatch wins. Reset mid-frame: immediate return to reset values,
//  relock needs a vs_fall plus LOCK_FRAMES clean frames. Sync inputs stuck: counts saturate -> error, SEARCH.
// STRUCTURE
//  Shared package vga_timing_pkg: H_/V_ sync, porch, display, line/frame constants (also used by the generator)
//  and FSM state encoding SEARCH=0, CHECK=1, LOCKED=2.
//  One sub-module: sync_edge_meter (register, edge detect, low-width counter), instantiated for HSync and VSync;
//  the VSync instance advances on hs_fall, not on every clock.
// TESTING
//  Nominal 800x525 timing, 3 frames -> o_locked=1 one cycle after 3rd vs_fall (LOCK_FRAMES=2), o_error never set.
//  Locked; one line of 799 clocks -> o_error pulse at that hs_fall, o_locked=0, relock after 3 further frames.
//  Locked; frame with 524 lines -> o_frame_lines=524, o_error at vs_fall, o_locked=0.
//  HSync low 91 clocks once -> width mismatch, o_error on HSync rise, SEARCH.
//  Syncs held high 2000 clocks -> o_h_count saturates at 1023, o_error if CHECK/LOCKED, then recovers.
//  i_Reset asserted mid-line at o_h_count=400 -> all outputs 0 that cycle; o_v_count 0 at next frame start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and sync monitor state encoding
package vga_timing_pkg;
  localparam int H_SYNC  = 92;
  localparam int H_BACK  = 50;
  localparam int H_DISP  = 640;
  localparam int H_FRONT = 18;
  localparam int H_LINE  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_DISP  = 480;
  localparam int V_FRONT = 10;
  localparam int V_FRAME = V_SYNC + V_BACK + V_DISP + V_FRONT;
  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} mon_state_t;
endpackage

// File: rtl/vga_sync_monitor_edge_meter.sv
// sync_edge_meter: registers an active-low sync, detects its edges and measures its low width
module sync_edge_meter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sync,
  input  logic       i_adv,
  output logic       o_fall,
  output logic       o_rise,
  output logic [9:0] o_width
);
  logic       r_s;
  logic       r_s_d;
  logic [9:0] r_w;
  // sample the sync once and keep one cycle of history; idle level is high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s   <= 1'b1;
      r_s_d <= 1'b1;
    end else begin
      r_s   <= i_sync;
      r_s_d <= r_s;
    end
  end
  assign o_fall  = r_s_d & ~r_s;
  assign o_rise  = ~r_s_d & r_s;
  assign o_width = r_w;
  // low width in advance events, the falling-edge event itself counts as the first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_w <= '0;
    else r_w <= o_fall ? {9'd0, i_adv} : ((~r_s & i_adv & ~(&r_w)) ? r_w + 10'd1 : r_w);
  end
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers raster position from looped-back VGA syncs and checks timing lock
module vga_sync_monitor #(
  parameter int H_LINE      = vga_timing_pkg::H_LINE,
  parameter int V_FRAME     = vga_timing_pkg::V_FRAME,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VGA_HSync,
  input  logic       i_VGA_VSync,
  output logic [9:0] o_h_count,
  output logic [9:0] o_v_count,
  output logic [9:0] o_line_len,
  output logic [9:0] o_frame_lines,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_error
);
  import vga_timing_pkg::*;
  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic [9:0] w_hs_w, w_vs_w, w_len_n, w_lines_n;
  logic       w_fs, w_mis, w_first_bad, w_clean, w_err;
  logic       r_pend;
  logic [9:0] r_h_count, r_v_count, r_line_len, r_frame_lines;
  mon_state_t r_state, w_state;
  logic [2:0] r_good, w_good;
  logic       r_dirty, w_dirty, r_first, w_first;

  sync_edge_meter u_hs (
    .i_clk  (i_Clk),
    .i_rst  (i_Reset),
    .i_sync (i_VGA_HSync),
    .i_adv  (1'b1),
    .o_fall (w_hs_fall),
    .o_rise (w_hs_rise),
    .o_width(w_hs_w)
  );

  sync_edge_meter u_vs (
    .i_clk  (i_Clk),
    .i_rst  (i_Reset),
    .i_sync (i_VGA_VSync),
    .i_adv  (w_hs_fall),
    .o_fall (w_vs_fall),
    .o_rise (w_vs_rise),
    .o_width(w_vs_w)
  );

  assign w_len_n     = r_h_count + 10'd1;
  assign w_lines_n   = r_v_count + 10'd1;
  assign w_fs        = w_hs_fall & (w_vs_fall | r_pend);
  assign w_mis       = (w_hs_fall & ~r_first & (w_len_n != 10'(H_LINE)))
                     | (w_hs_rise & (w_hs_w != 10'(H_SYNC)))
                     | (w_vs_rise & (w_vs_w != 10'(V_SYNC)))
                     | (&r_h_count) | (&r_v_count);
  assign w_first_bad = w_hs_fall & r_first & (w_len_n != 10'(H_LINE));
  assign w_clean     = (w_lines_n == 10'(V_FRAME)) & ~r_dirty & ~w_first_bad;

  // raster counters and measured line/frame lengths, updated in every state
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_pend        <= 1'b0;
    end else begin
      r_h_count     <= w_hs_fall ? '0 : ((&r_h_count) ? r_h_count : w_len_n);
      r_line_len    <= w_hs_fall ? w_len_n : r_line_len;
      r_v_count     <= w_fs ? '0 : ((w_hs_fall & ~(&r_v_count)) ? w_lines_n : r_v_count);
      r_frame_lines <= w_fs ? w_lines_n : r_frame_lines;
      r_pend        <= w_hs_fall ? 1'b0 : (w_vs_fall | r_pend);
    end
  end

  // lock state register with good-frame count and first-line/dirty tracking
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= SEARCH;
      r_good  <= '0;
      r_dirty <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state;
      r_good  <= w_good;
      r_dirty <= w_dirty;
      r_first <= w_first;
    end
  end

  // lock decisions; a mismatch always takes priority over a frame start
  always_comb begin
    w_state = r_state;
    w_good  = r_good;
    w_dirty = r_dirty;
    w_first = w_hs_fall ? 1'b0 : r_first;
    w_err   = 1'b0;
    case (r_state)
      SEARCH: if (w_vs_fall) begin
        w_state = CHECK;
        w_good  = '0;
        w_dirty = 1'b0;
        w_first = 1'b1;
      end
      CHECK: if (w_mis) begin
        w_err   = 1'b1;
        w_state = SEARCH;
      end else if (w_vs_fall) begin
        w_dirty = 1'b0;
        w_good  = w_clean ? r_good + 3'd1 : '0;
        w_state = (w_clean & ({1'b0, r_good} + 4'd1 == 4'(LOCK_FRAMES))) ? LOCKED : CHECK;
      end else begin
        w_dirty = r_dirty | w_first_bad;
      end
      LOCKED: if (w_mis | (w_vs_fall & (w_lines_n != 10'(V_FRAME)))) begin
        w_err   = 1'b1;
        w_state = SEARCH;
      end
      default: w_state = SEARCH;
    endcase
  end

  assign o_h_count     = r_h_count;
  assign o_v_count     = r_v_count;
  assign o_line_len    = r_line_len;
  assign o_frame_lines = r_frame_lines;
  assign o_frame_start = w_vs_fall;
  assign o_locked      = r_state == LOCKED;
  assign o_error       = w_err;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed raster scenarios on a scaled-down timing with hand-derived expectations
module tb_vga_sync_monitor;
  localparam int HL = 40;
  localparam int HS = 6;
  localparam int VF = 12;
  localparam int VS = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [9:0] h_count, v_count, line_len, frame_lines;
  logic       frame_start, locked, error;
  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         e0;

  vga_sync_monitor #(
    .H_LINE     (HL),
    .V_FRAME    (VF),
    .H_SYNC     (HS),
    .V_SYNC     (VS),
    .LOCK_FRAMES(2)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_VGA_HSync  (hs),
    .i_VGA_VSync  (vs),
    .o_h_count    (h_count),
    .o_v_count    (v_count),
    .o_line_len   (line_len),
    .o_frame_lines(frame_lines),
    .o_frame_start(frame_start),
    .o_locked     (locked),
    .o_error      (error)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v);
    hs = h;
    vs = v;
    @(posedge clk);
    #1;
    err_pulses += int'(error);
  endtask

  task automatic line(input int len, input int hlow, input logic v, input int from);
    for (int i = from; i < len; i++) tick(i >= hlow, v);
  endtask

  task automatic frame(input int fl, input int nl, input int bl, input int blen, input int bhl);
    for (int l = fl; l < nl; l++) line(l == bl ? blen : HL, l == bl ? bhl : HS, l >= VS, 0);
  endtask

  initial begin
    repeat (3) tick(1'b1, 1'b1);
    check("rst_h", h_count, 0);
    check("rst_v", v_count, 0);
    check("rst_len", line_len, 0);
    check("rst_lines", frame_lines, 0);
    check("rst_flags", {frame_start, locked, error}, 0);
    rst = 1'b0;
    repeat (10) tick(1'b1, 1'b1);
    frame(0, VF, -1, HL, HS);
    frame(0, VF, -1, HL, HS);
    tick(1'b0, 1'b0);
    check("a_fs", frame_start, 1);
    check("a_lock_pre", locked, 0);
    check("a_h_end", h_count, HL - 1);
    check("a_v_end", v_count, VF - 1);
    tick(1'b0, 1'b0);
    check("a_lock", locked, 1);
    check("a_h0", h_count, 0);
    check("a_v0", v_count, 0);
    check("a_lines", frame_lines, VF);
    check("a_len", line_len, HL);
    check("a_no_err", err_pulses, 0);
    line(HL, HS, 1'b0, 2);
    frame(1, 6, 5, HL - 1, HS);
    tick(1'b0, 1'b1);
    check("b_err", error, 1);
    check("b_len_old", line_len, HL);
    tick(1'b0, 1'b1);
    check("b_unlock", locked, 0);
    check("b_len", line_len, HL - 1);
    line(HL, HS, 1'b1, 2);
    frame(7, VF, -1, HL, HS);
    repeat (3) frame(0, VF, -1, HL, HS);
    check("b_relock", locked, 1);
    check("b_err_cnt", err_pulses, 1);
    frame(0, VF - 1, -1, HL, HS);
    tick(1'b0, 1'b0);
    check("c_err", error, 1);
    check("c_fs", frame_start, 1);
    tick(1'b0, 1'b0);
    check("c_lines", frame_lines, VF - 1);
    check("c_unlock", locked, 0);
    line(HL, HS, 1'b0, 2);
    frame(1, VF, -1, HL, HS);
    repeat (3) frame(0, VF, -1, HL, HS);
    check("d_lock", locked, 1);
    frame(0, 4, -1, HL, HS);
    line(HS - 1, HS - 1, 1'b1, 0);
    tick(1'b1, 1'b1);
    check("d_err", error, 1);
    tick(1'b1, 1'b1);
    check("d_unlock", locked, 0);
    line(HL, HS, 1'b1, HS + 1);
    frame(5, VF, -1, HL, HS);
    frame(0, VF, -1, HL, HS);
    e0 = err_pulses;
    repeat (2000) tick(1'b1, 1'b1);
    check("e_sat", h_count, 1023);
    check("e_err_once", err_pulses - e0, 1);
    check("e_unlock", locked, 0);
    check("e_len", line_len, HL);
    repeat (3) frame(0, VF, -1, HL, HS);
    check("e_relock", locked, 1);
    e0 = err_pulses;
    frame(0, 3, -1, HL, HS);
    line(22, HS, 1'b1, 0);
    check("f_h20", h_count, 20);
    rst = 1'b1;
    #1;
    check("f_h", h_count, 0);
    check("f_v", v_count, 0);
    check("f_len", line_len, 0);
    check("f_lines", frame_lines, 0);
    check("f_lock", locked, 0);
    repeat (2) tick(1'b1, 1'b1);
    rst = 1'b0;
    line(HL, HS, 1'b1, 24);
    frame(4, VF, -1, HL, HS);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("f_v0", v_count, 0);
    check("f_nolock", locked, 0);
    line(HL, HS, 1'b0, 2);
    frame(1, VF, -1, HL, HS);
    frame(0, VF, -1, HL, HS);
    tick(1'b0, 1'b0);
    check("f_lock_pre", locked, 0);
    tick(1'b0, 1'b0);
    check("f_relock", locked, 1);
    check("f_no_err", err_pulses - e0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
